uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the basic UART receiver in the JE6850 path.
- Consumes the UART's single-entry receive register (rdr/rdrf) and acknowledges each byte with a one-cycle rdrrd pulse.
- Stores received bytes in a circular FIFO so the CPU-side 6850 register logic can drain bursts without losing characters.
- Presents first-word-fall-through data, fill level, threshold and overrun status to the bus side.

Parameters:
- DATA_WIDTH, 8, width of one received character.
- DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16 entries).
- THRESH, 12, fill level at or above which thresh_hit asserts; legal range 1..2**DEPTH_LOG2.

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- rdr  input  DATA_WIDTH  received character from the UART
- rdrf  input  1  UART receive register full
- fe  input  1  UART frame-error pulse, coincident with the cycle rdrf first rises
- rdrrd  output  1  one-cycle acknowledge to the UART, clears its rdrf
- rd_data  output  DATA_WIDTH  head-of-FIFO character, valid while rd_valid=1
- rd_valid  output  1  FIFO not empty
- rd_pop  input  1  consume head entry; ignored when rd_valid=0
- count  output  DEPTH_LOG2+1  current number of stored entries, 0..2**DEPTH_LOG2
- thresh_hit  output  1  count >= THRESH
- ovr  output  1  sticky overrun flag
- ovr_clr  input  1  clears ovr
- flush  input  1  synchronous empty of the FIFO

Behaviour:
- Reset (async, rstn=0): pointers=0, count=0, rdrrd=0, ovr=0, rd_valid=0, thresh_hit=0, rd_data=0. Storage contents are don't-care.
- Capture condition: rdrf=1 and rdrrd=0.
  - rdrrd is registered and asserted the cycle after capture, for exactly one cycle.
  - rdrf is still high during the rdrrd cycle; the rdrrd=0 qualifier prevents a double capture.
  - Minimum spacing between captures is 2 cycles.
- Push occurs on a capture edge when count < depth OR rd_pop=1 with rd_valid=1 on the same edge.
  - The character is written at wr_ptr and wr_ptr increments.
- Full with no simultaneous pop:
  - The character is dropped and rdrrd is still pulsed, so the UART is always drained.
  - ovr sets on the same edge.
  - count, pointers and stored data are unchanged.
- Pop (rd_pop=1 and rd_valid=1): rd_ptr increments.
- Simultaneous push and pop: both occur and count is unchanged; this also holds at full and at count=1.
- Pointers: DEPTH_LOG2 bits wide, wrap naturally from 2**DEPTH_LOG2-1 to 0.
- count is a registered up/down counter: +1 on push only, -1 on pop only.
- rd_valid = (count != 0).
- thresh_hit = (count >= THRESH); registered and consistent with count in the same cycle.
- rd_data = storage[rd_ptr]. It follows rd_ptr combinationally and is stable while no pop occurs.
- Latency: a byte captured on edge N is visible with rd_valid=1 after edge N.
- ovr_clr: clears ovr on the next edge. If ovr_clr and a new overrun occur on the same edge, set wins and ovr stays 1.
- flush: on the next edge, sets pointers and count to 0.
  - A capture on the same edge is discarded but still acknowledged with rdrrd.
  - flush does not change ovr.
- fe is sampled only on capture edges and ignored at all other times.

Optional Feature:
- Macro: UART_RX_FIFO_FE_TAG_EN.
- With the macro defined:
  - Each entry is DATA_WIDTH+1 bits wide, storing fe alongside the character.
  - An extra output rd_fe (1 bit) gives the tag of the head entry, valid while rd_valid=1; reset value 0.
  - A dropped byte's fe is also discarded.
- Without the macro: entries are DATA_WIDTH bits wide, there is no rd_fe port, and fe is unused.

Test Plan:
- Single byte: rdrf=1 with rdr=0x41 held until rdrrd → rdrrd high exactly one cycle; rd_valid=1, rd_data=0x41, count=1; rd_pop → count=0, rd_valid=0.
- Fill: 16 bytes 0x00..0x0F → count=16, thresh_hit rises on the 12th push; drained in order 0x00..0x0F; ovr stays 0.
- Overrun: full FIFO plus one more byte 0xEE → rdrrd still pulsed, ovr=1, count=16, 0xEE never appears on readout; ovr_clr → ovr=0.
- Pop while full: pop and capture of 0x55 on the same edge → count stays 16; 0x55 is read last; ovr=0.
- Wrap and flush: 40 push/pop pairs across the pointer wrap → data order preserved; flush with count=5 → count=0, rd_valid=0, ovr unchanged.
- FE tag (macro on) and async reset: byte 0x7F with fe=1 → rd_fe=1 at head; assert rstn low mid-stream while rdrrd=1 → all outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the basic UART receiver and the 6850 bus-side
// register logic. Each byte held in the UART's single-entry receive register
// (rdr/rdrf) is captured, acknowledged with a one-cycle rdrrd pulse, and written
// into a circular FIFO. The head entry is presented first-word-fall-through.
//
// Optional build macro: UART_RX_FIFO_FE_TAG_EN
//   When defined, each entry also stores the frame-error bit (fe) and the head tag
//   is presented on rd_fe. When undefined, fe is unused and rd_fe does not exist.
//
// Ports:
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset
//   rdr        in   received character from the UART
//   rdrf       in   UART receive register full
//   fe         in   UART frame-error flag, sampled only on capture edges
//   rdrrd      out  one-cycle acknowledge to the UART (clears its rdrf)
//   rd_data    out  head-of-FIFO character, valid while rd_valid=1 (0 when empty)
//   rd_fe      out  head-of-FIFO frame-error tag (macro builds only)
//   rd_valid   out  FIFO not empty
//   rd_pop     in   consume head entry; ignored when empty
//   count      out  number of stored entries, 0..2**DEPTH_LOG2
//   thresh_hit out  count >= THRESH
//   ovr        out  sticky overrun flag
//   ovr_clr    in   clears ovr (a simultaneous new overrun wins)
//   flush      in   synchronous empty of the FIFO
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned THRESH     = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] rdr,
  input  logic                  rdrf,
  input  logic                  fe,
  output logic                  rdrrd,
  output logic [DATA_WIDTH-1:0] rd_data,
`ifdef UART_RX_FIFO_FE_TAG_EN
  output logic                  rd_fe,
`endif
  output logic                  rd_valid,
  input  logic                  rd_pop,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  thresh_hit,
  output logic                  ovr,
  input  logic                  ovr_clr,
  input  logic                  flush
);

  localparam int unsigned          Depth     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  DepthCnt  = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]  ThreshCnt = (DEPTH_LOG2 + 1)'(THRESH);
`ifdef UART_RX_FIFO_FE_TAG_EN
  localparam int unsigned          EntryW    = DATA_WIDTH + 1;
`else
  localparam int unsigned          EntryW    = DATA_WIDTH;
`endif

  // Storage is not reset; only pointers and count define which entries are live.
  logic [EntryW-1:0]     mem_q [Depth];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  rdrrd_q, rdrrd_d;
  logic                  ovr_q, ovr_d;
  logic                  thresh_q, thresh_d;

  logic                  capture;
  logic                  pop;
  logic                  full;
  logic                  push;
  logic                  drop;
  logic [EntryW-1:0]     wr_entry;
  logic [EntryW-1:0]     head_entry;

  // ---------------------------------------------------------------------------
  // Entry formatting
  // ---------------------------------------------------------------------------
`ifdef UART_RX_FIFO_FE_TAG_EN
  assign wr_entry = {fe, rdr};
`else
  logic unused_fe;
  assign unused_fe = fe;
  assign wr_entry  = rdr;
`endif

  // ---------------------------------------------------------------------------
  // Transfer qualification
  // ---------------------------------------------------------------------------
  // rdrf stays high during the acknowledge cycle, so the registered rdrrd masks it
  // to avoid capturing the same character twice.
  assign capture = rdrf & ~rdrrd_q;
  assign pop     = rd_pop & (count_q != '0);
  assign full    = (count_q == DepthCnt);
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push    = capture & ~flush & (~full | pop);
  // Flush discards a coincident capture without flagging overrun.
  assign drop    = capture & ~flush & full & ~pop;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdrrd_d  = capture;
    ovr_d    = ovr_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // Set has priority over clear.
    if (drop) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end

    // Derived from count_d so the registered flag always matches count.
    thresh_d = (count_d >= ThreshCnt);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdrrd_q  <= 1'b0;
      ovr_q    <= 1'b0;
      thresh_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdrrd_q  <= rdrrd_d;
      ovr_q    <= ovr_d;
      thresh_q <= thresh_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign head_entry = mem_q[rd_ptr_q];

  // Head data is forced to zero while empty so reset and idle outputs are defined
  // even though storage is never initialised.
  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? head_entry[DATA_WIDTH-1:0] : '0;
`ifdef UART_RX_FIFO_FE_TAG_EN
  assign rd_fe      = rd_valid ? head_entry[DATA_WIDTH] : 1'b0;
`endif
  assign count      = count_q;
  assign thresh_hit = thresh_q;
  assign ovr        = ovr_q;
  assign rdrrd      = rdrrd_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. A queue-based reference model tracks the
// FIFO contents, the acknowledge pulse and the overrun flag; a small UART model
// presents bytes from a transmit queue and drops rdrf after each acknowledge.
module tb_uart_rx_fifo;
  localparam int Depth  = 16;
  localparam int Thresh = 12;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] rdr = 8'h00;
  logic       rdrf = 1'b0;
  logic       fe = 1'b0;
  logic       rd_pop = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       flush = 1'b0;
  logic       rdrrd;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] count;
  logic       thresh_hit;
  logic       ovr;
`ifdef UART_RX_FIFO_FE_TAG_EN
  logic       rd_fe;
`endif

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_WIDTH (8),
    .DEPTH_LOG2 (4),
    .THRESH     (Thresh)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rdr        (rdr),
    .rdrf       (rdrf),
    .fe         (fe),
    .rdrrd      (rdrrd),
    .rd_data    (rd_data),
`ifdef UART_RX_FIFO_FE_TAG_EN
    .rd_fe      (rd_fe),
`endif
    .rd_valid   (rd_valid),
    .rd_pop     (rd_pop),
    .count      (count),
    .thresh_hit (thresh_hit),
    .ovr        (ovr),
    .ovr_clr    (ovr_clr),
    .flush      (flush)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {fe, data}, acknowledge state, overrun flag.
  logic [8:0] mq[$];
  logic [8:0] tx[$];
  bit         m_ack = 1'b0;
  bit         m_ovr = 1'b0;
  bit         was_ack = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ack = 1'b0;
    m_ovr = 1'b0;
    was_ack = 1'b0;
  endtask

  // Applies one clock edge worth of behaviour to the model.
  task automatic model_edge();
    bit cap;
    bit popv;
    bit set_ovr;
    int n;
    cap     = rdrf && !m_ack;
    popv    = rd_pop && (mq.size() != 0);
    n       = mq.size();
    set_ovr = 1'b0;
    was_ack = m_ack;
    if (flush) begin
      mq.delete();
    end else begin
      if (popv) void'(mq.pop_front());
      if (cap) begin
        if (n < Depth || popv) mq.push_back({fe, rdr});
        else set_ovr = 1'b1;
      end
    end
    if (set_ovr) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    m_ack = cap;
  endtask

  task automatic check_outputs();
    chk("rdrrd", rdrrd, m_ack);
    chk("rd_valid", rd_valid, mq.size() != 0);
    chk("count", count, mq.size());
    chk("thresh_hit", thresh_hit, mq.size() >= Thresh);
    chk("ovr", ovr, m_ovr);
    if (mq.size() != 0) begin
      chk("rd_data", rd_data, mq[0][7:0]);
`ifdef UART_RX_FIFO_FE_TAG_EN
      chk("rd_fe", rd_fe, mq[0][8]);
`endif
    end
  endtask

  // UART side: drop rdrf after an acknowledge cycle, then offer the next byte.
  task automatic uart_update();
    logic [8:0] e;
    if (was_ack) rdrf = 1'b0;
    if (!rdrf && tx.size() != 0) begin
      e    = tx.pop_front();
      rdr  = e[7:0];
      fe   = e[8];
      rdrf = 1'b1;
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    uart_update();
  endtask

  task automatic run_drain();
    for (int i = 0; i < 300; i++) begin
      if (tx.size() == 0 && !rdrf) break;
      step();
    end
    chk("drain_bound", (tx.size() != 0) || rdrf, 0);
  endtask

  logic [7:0] got[$];
  bit         ovr_before;

  initial begin
    // Reset values
    #1;
    chk("rst_rdrrd", rdrrd, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_thresh", thresh_hit, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    step();

    // Single byte
    tx.push_back({1'b0, 8'h41});
    run_drain();
    chk("single_count", count, 1);
    chk("single_data", rd_data, 8'h41);
    rd_pop = 1'b1;
    step();
    rd_pop = 1'b0;
    chk("single_empty", rd_valid, 0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) tx.push_back({1'b0, 8'(i)});
    run_drain();
    chk("fill_count", count, 16);
    chk("fill_thresh", thresh_hit, 1);
    chk("fill_ovr", ovr, 0);

    // Overrun with 0xEE
    tx.push_back({1'b0, 8'hEE});
    run_drain();
    chk("ovr_set", ovr, 1);
    chk("ovr_count", count, 16);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("ovr_clr", ovr, 0);

    // Pop while full, coincident with capture of 0x55
    rdrf   = 1'b1;
    rdr    = 8'h55;
    fe     = 1'b0;
    rd_pop = 1'b1;
    step();
    rd_pop = 1'b0;
    step();
    chk("popfull_count", count, 16);
    chk("popfull_ovr", ovr, 0);
    got.delete();
    for (int i = 0; i < 16; i++) begin
      got.push_back(rd_data);
      rd_pop = 1'b1;
      step();
    end
    rd_pop = 1'b0;
    chk("drain_first", got[0], 8'h01);
    chk("drain_0f", got[14], 8'h0F);
    chk("drain_last_55", got[15], 8'h55);
    chk("drain_empty", rd_valid, 0);

    // Push/pop pairs across the pointer wrap
    for (int i = 0; i < 40; i++) begin
      tx.push_back({1'b0, 8'($urandom)});
      run_drain();
      rd_pop = 1'b1;
      step();
      rd_pop = 1'b0;
    end

    // Overrun, partial drain to count 5, then flush
    for (int i = 0; i < 17; i++) tx.push_back({1'b0, 8'($urandom)});
    run_drain();
    rd_pop = 1'b1;
    for (int i = 0; i < 11; i++) step();
    rd_pop = 1'b0;
    chk("preflush_count", count, 5);
    ovr_before = m_ovr;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", rd_valid, 0);
    chk("flush_ovr", ovr, ovr_before);
    chk("flush_ovr_kept", ovr, 1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;

    // Frame-error tag
    tx.push_back({1'b1, 8'h7F});
    run_drain();
    chk("fe_data", rd_data, 8'h7F);
`ifdef UART_RX_FIFO_FE_TAG_EN
    chk("fe_tag", rd_fe, 1);
`endif
    rd_pop = 1'b1;
    step();
    rd_pop = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (((c / 100) % 2) == 1) rd_pop = ($urandom % 4) != 0;
      else rd_pop = ($urandom % 4) == 0;
      ovr_clr = ($urandom % 20) == 0;
      flush   = ($urandom % 90) == 0;
      if (tx.size() < 2 && ($urandom % 3) != 0) tx.push_back(9'($urandom));
      step();
    end
    rd_pop  = 1'b0;
    ovr_clr = 1'b0;
    flush   = 1'b0;
    tx.delete();
    run_drain();

    // Asynchronous reset while rdrrd is high
    rdrf = 1'b1;
    rdr  = 8'hA5;
    fe   = 1'b1;
    step();
    chk("prereset_ack", rdrrd, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_rdrrd", rdrrd, 0);
    chk("arst_count", count, 0);
    chk("arst_valid", rd_valid, 0);
    chk("arst_thresh", thresh_hit, 0);
    chk("arst_ovr", ovr, 0);
    chk("arst_rd_data", rd_data, 0);
`ifdef UART_RX_FIFO_FE_TAG_EN
    chk("arst_rd_fe", rd_fe, 0);
`endif
    rdrf = 1'b0;
    fe   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
